// File: rtl/dmem_portb_arbiter.sv
// DMEM port-B arbiter: shares the BRAM port between accelerator reads and
// CCD row writes. Accelerator has default priority. The CCD engine is forced
// through after STARVE_MAX consecutive lost cycles. Port-B strobes are
// registered. A shift register tracks read latency so that the accelerator
// gets a qualified read-data strobe.
module dmem_portb_arbiter #(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 256,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              acc_req,
    input  logic [ADDR_W-1:0] acc_addr,
    output logic              acc_gnt,
    output logic              acc_rvalid,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              acc_rd_pending,

    input  logic              ccd_req,
    input  logic [ADDR_W-1:0] ccd_addr,
    input  logic [DATA_W-1:0] ccd_wdata,
    output logic              ccd_gnt,

    output logic [ADDR_W-1:0] ram_addr_b,
    output logic [DATA_W-1:0] ram_data_b,
    output logic              ram_rden_b,
    output logic              ram_wren_b,
    input  logic [DATA_W-1:0] ram_q_b
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              rden_q, rden_d;
    logic              wren_q, wren_d;
    logic [RD_LAT-1:0] pipe_q;

    logic              ccd_force;
    logic              acc_win;
    logic              ccd_win;

    // Grant decision: CCD wins when alone or when it has waited STARVE_MAX cycles.
    always_comb begin
        ccd_force = ccd_req && (starve_q == STARVE_LIM);
        ccd_win   = !rst && ccd_req && (!acc_req || ccd_force);
        acc_win   = !rst && acc_req && !ccd_win;
    end

    // Starvation counter: counts CCD cycles lost to the accelerator, saturating.
    always_comb begin
        starve_d = starve_q;
        if (ccd_win || !ccd_req) begin
            starve_d = 4'd0;
        end else if (acc_win && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Next port-B command: strobes last one cycle; address/data hold when idle.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        rden_d = 1'b0;
        wren_d = 1'b0;
        if (acc_win) begin
            addr_d = acc_addr;
            rden_d = 1'b1;
        end else if (ccd_win) begin
            addr_d = ccd_addr;
            data_d = ccd_wdata;
            wren_d = 1'b1;
        end
    end

    // Registered state. Reset also flushes in-flight reads from the return pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= 4'd0;
            addr_q   <= '0;
            data_q   <= '0;
            rden_q   <= 1'b0;
            wren_q   <= 1'b0;
            pipe_q   <= '0;
        end else begin
            starve_q  <= starve_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            pipe_q[0] <= rden_q;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign acc_gnt        = acc_win;
    assign ccd_gnt        = ccd_win;
    assign ram_addr_b     = addr_q;
    assign ram_data_b     = data_q;
    assign ram_rden_b     = rden_q;
    assign ram_wren_b     = wren_q;
    assign acc_rvalid     = pipe_q[RD_LAT-1];
    assign acc_rdata      = ram_q_b;
    assign acc_rd_pending = rden_q | (|pipe_q);

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Bench for dmem_portb_arbiter. It contains a BRAM model with RD_LAT read
// latency and a behavioural reference model that tracks the expected port-B
// commands, the read returns and the grants. It runs directed scenarios first
// and then randomized traffic with occasional resets.
module tb_dmem_portb_arbiter;

    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 256;
    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;
    localparam int NSLOT      = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              acc_req;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_gnt;
    logic              acc_rvalid;
    logic [DATA_W-1:0] acc_rdata;
    logic              acc_rd_pending;
    logic              ccd_req;
    logic [ADDR_W-1:0] ccd_addr;
    logic [DATA_W-1:0] ccd_wdata;
    logic              ccd_gnt;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_data_b;
    logic              ram_rden_b;
    logic              ram_wren_b;
    logic [DATA_W-1:0] ram_q_b;

    int cmp_cnt = 0;
    int err_cnt = 0;

    dmem_portb_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .acc_req(acc_req), .acc_addr(acc_addr), .acc_gnt(acc_gnt),
        .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata), .acc_rd_pending(acc_rd_pending),
        .ccd_req(ccd_req), .ccd_addr(ccd_addr), .ccd_wdata(ccd_wdata), .ccd_gnt(ccd_gnt),
        .ram_addr_b(ram_addr_b), .ram_data_b(ram_data_b),
        .ram_rden_b(ram_rden_b), .ram_wren_b(ram_wren_b), .ram_q_b(ram_q_b)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_init(int i);
        logic [31:0] w;
        w = 32'(i) * 32'h9E3779B9 + 32'h0000_0055;
        return {8{w}};
    endfunction

    function automatic logic [DATA_W-1:0] rand256();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- BRAM model (environment) ----------------
    logic              init_mem = 1'b1;
    logic [DATA_W-1:0] mem [128];
    logic [DATA_W-1:0] rdq [RD_LAT];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 128; i++) mem[i] <= mem_init(i);
        end else if (ram_wren_b) begin
            mem[ram_addr_b] <= ram_data_b;
        end
        rdq[0] <= ram_rden_b ? mem[ram_addr_b] : rand256();
        for (int i = 1; i < RD_LAT; i++) rdq[i] <= rdq[i-1];
    end
    assign ram_q_b = rdq[RD_LAT-1];

    // ---------------- reference model + per-cycle compare ----------------
    logic              chk_on = 1'b0;
    logic              acc_took = 1'b0;
    logic              ccd_took = 1'b0;

    initial begin : model
        logic [DATA_W-1:0] ref_mem [128];
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        logic              e_rden, e_wren;
        bit                ev_rv   [NSLOT];
        bit                ev_pend [NSLOT];
        logic [DATA_W-1:0] ev_d    [NSLOT];
        int                ptr, lost, s;
        logic              m_ag, m_cg, ccd_due;

        for (int i = 0; i < 128; i++) ref_mem[i] = mem_init(i);
        for (int i = 0; i < NSLOT; i++) begin
            ev_rv[i] = 0; ev_pend[i] = 0; ev_d[i] = '0;
        end
        e_addr = '0; e_data = '0; e_rden = 0; e_wren = 0;
        ptr = 0; lost = 0;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                ccd_due = (lost >= STARVE_MAX);
                m_cg = 1'b0;
                m_ag = 1'b0;
                if (!rst) begin
                    if (ccd_req && (ccd_due || !acc_req)) m_cg = 1'b1;
                    else if (acc_req)                     m_ag = 1'b1;
                end
                chk("acc_gnt",        256'(acc_gnt),        256'(m_ag));
                chk("ccd_gnt",        256'(ccd_gnt),        256'(m_cg));
                chk("ram_rden_b",     256'(ram_rden_b),     256'(e_rden));
                chk("ram_wren_b",     256'(ram_wren_b),     256'(e_wren));
                chk("ram_addr_b",     256'(ram_addr_b),     256'(e_addr));
                chk("ram_data_b",     ram_data_b,           e_data);
                chk("acc_rvalid",     256'(acc_rvalid),     256'(ev_rv[ptr]));
                chk("acc_rd_pending", 256'(acc_rd_pending), 256'(ev_pend[ptr]));
                if (ev_rv[ptr]) chk("acc_rdata", acc_rdata, ev_d[ptr]);

                ev_rv[ptr] = 0;
                ev_pend[ptr] = 0;
                e_rden = 0;
                e_wren = 0;
                if (rst) begin
                    e_addr = '0;
                    e_data = '0;
                    lost   = 0;
                    for (int k = 1; k < NSLOT; k++) begin
                        ev_rv[(ptr + k) % NSLOT] = 0;
                        ev_pend[(ptr + k) % NSLOT] = 0;
                    end
                end else begin
                    if (m_ag) begin
                        e_addr = acc_addr;
                        e_rden = 1;
                        s = (ptr + 1 + RD_LAT) % NSLOT;
                        ev_rv[s] = 1;
                        ev_d[s]  = ref_mem[acc_addr];
                        for (int k = 1; k <= 1 + RD_LAT; k++) ev_pend[(ptr + k) % NSLOT] = 1;
                    end else if (m_cg) begin
                        e_addr = ccd_addr;
                        e_data = ccd_wdata;
                        e_wren = 1;
                        ref_mem[ccd_addr] = ccd_wdata;
                    end
                    if (!ccd_req || m_cg) lost = 0;
                    else if (m_ag && lost < STARVE_MAX) lost = lost + 1;
                end
                acc_took = m_ag;
                ccd_took = m_cg;
                ptr = (ptr + 1) % NSLOT;
            end
        end
    end

    // ---------------- stimulus: directed then random ----------------
    initial begin : stim
        logic [11:0]       seq;
        logic [7:0]        rd_bits, rv_bits;
        logic [DATA_W-1:0] rvd [8];
        logic [DATA_W-1:0] pat;

        pat = {16{16'hA5A5}};
        rst = 1'b1; acc_req = 1'b1; ccd_req = 1'b1;
        acc_addr = 7'h11; ccd_addr = 7'h22; ccd_wdata = '0;

        // reset with both requesters active
        tick(); init_mem = 1'b0; chk_on = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst_acc_gnt", 256'(acc_gnt), 256'(0));
        chk("rst_ccd_gnt", 256'(ccd_gnt), 256'(0));
        tick(); rst = 1'b0; acc_req = 1'b0; ccd_req = 1'b0;
        @(negedge clk);
        chk("rel_rden",   256'(ram_rden_b), 256'(0));
        chk("rel_wren",   256'(ram_wren_b), 256'(0));
        chk("rel_addr",   256'(ram_addr_b), 256'(0));
        chk("rel_data",   ram_data_b,       256'(0));
        chk("rel_rvalid", 256'(acc_rvalid), 256'(0));
        chk("rel_pend",   256'(acc_rd_pending), 256'(0));

        // single read of 0x05
        tick(); acc_req = 1'b1; acc_addr = 7'h05;
        @(negedge clk); chk("rd5_gnt", 256'(acc_gnt), 256'(1));
        tick(); acc_req = 1'b0;
        @(negedge clk);
        chk("rd5_rden", 256'(ram_rden_b), 256'(1));
        chk("rd5_addr", 256'(ram_addr_b), 256'(7'h05));
        chk("rd5_pend1", 256'(acc_rd_pending), 256'(1));
        tick();
        @(negedge clk);
        chk("rd5_pend2", 256'(acc_rd_pending), 256'(1));
        chk("rd5_early", 256'(acc_rvalid), 256'(0));
        tick();
        @(negedge clk);
        chk("rd5_rvalid", 256'(acc_rvalid), 256'(1));
        chk("rd5_rdata",  acc_rdata, mem_init(5));

        // single write of 0x7F, then read it back
        tick(); ccd_req = 1'b1; ccd_addr = 7'h7F; ccd_wdata = pat;
        @(negedge clk); chk("wr_gnt", 256'(ccd_gnt), 256'(1));
        tick(); ccd_req = 1'b0;
        @(negedge clk);
        chk("wr_wren", 256'(ram_wren_b), 256'(1));
        chk("wr_addr", 256'(ram_addr_b), 256'(7'h7F));
        chk("wr_data", ram_data_b, pat);
        tick();
        @(negedge clk); chk("wr_wren_off", 256'(ram_wren_b), 256'(0));
        tick(); acc_req = 1'b1; acc_addr = 7'h7F;
        @(negedge clk); chk("rb_gnt", 256'(acc_gnt), 256'(1));
        tick(); acc_req = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rb_rvalid", 256'(acc_rvalid), 256'(1));
        chk("rb_rdata",  acc_rdata, pat);

        // continuous contention: A,A,A,A,C,A,A,A,A,C,A,A
        tick(); acc_req = 1'b1; acc_addr = 7'h30; ccd_req = 1'b1; ccd_addr = 7'h40; ccd_wdata = rand256();
        seq = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            seq[k] = ccd_gnt;
            if (k < 11) tick();
        end
        chk("contention_seq", 256'(seq), 256'(12'h210));
        tick(); acc_req = 1'b0; ccd_req = 1'b0;
        repeat (6) tick();

        // back-to-back reads of 0x01..0x03
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            acc_req = (k < 3);
            if (k < 3) acc_addr = 7'(k + 1);
            @(negedge clk);
            rd_bits[k] = ram_rden_b;
            rv_bits[k] = acc_rvalid;
            rvd[k]     = acc_rdata;
        end
        chk("b2b_rden",   256'(rd_bits), 256'(8'b0000_1110));
        chk("b2b_rvalid", 256'(rv_bits), 256'(8'b0011_1000));
        chk("b2b_data1",  rvd[3], mem_init(1));
        chk("b2b_data2",  rvd[4], mem_init(2));
        chk("b2b_data3",  rvd[5], mem_init(3));

        // reset right after a read grant discards the read
        tick(); acc_req = 1'b1; acc_addr = 7'h09;
        @(negedge clk); chk("rr_gnt", 256'(acc_gnt), 256'(1));
        tick(); acc_req = 1'b0; rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("rr_rden", 256'(ram_rden_b), 256'(0));
        chk("rr_pend", 256'(acc_rd_pending), 256'(0));
        rv_bits = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            rv_bits[k] = acc_rvalid | acc_rd_pending;
        end
        chk("rr_no_return", 256'(rv_bits), 256'(0));

        // randomized traffic with occasional resets and ccd_req drops
        for (int n = 0; n < 3000; n++) begin
            tick();
            rst = ($urandom_range(0, 199) == 0);
            if (!acc_req || acc_took) begin
                acc_req  = ($urandom_range(0, 2) != 0);
                acc_addr = 7'($urandom);
            end
            if (!ccd_req || ccd_took) begin
                ccd_req   = ($urandom_range(0, 2) != 0);
                ccd_addr  = 7'($urandom);
                ccd_wdata = rand256();
            end else if ($urandom_range(0, 39) == 0) begin
                ccd_req = 1'b0;
            end
        end
        tick(); acc_req = 1'b0; ccd_req = 1'b0; rst = 1'b0;
        repeat (8) tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_portb_arbiter.md
# dmem_portb_arbiter

Arbitrates the shared port B of the DMEM block RAM (128 x 256-bit) between the accelerator's BRAM read requests and the CCD capture engine's row writes. It replaces the fixed-priority address/enable mux with a registered, starvation-bounded arbiter. It also tracks read latency so the accelerator receives a qualified read-data strobe. It sits between the accelerator, the CCD engine, and DMEM port B.

## Interface
- ADDR_W, 7, port-B word address width
- DATA_W, 256, port-B data width (16 x 16-bit)
- RD_LAT, 2, cycles from `ram_rden_b` asserted to `ram_q_b` valid (legal 1..4)
- STARVE_MAX, 4, max consecutive lost arbitration cycles for CCD before it is forced to win (legal 1..15)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- acc_req  in  1  accelerator read request, held until granted
- acc_addr  in  ADDR_W  read address, stable while acc_req
- acc_gnt  out  1  read accepted this cycle (combinational)
- acc_rvalid  out  1  acc_rdata valid this cycle
- acc_rdata  out  DATA_W  read data (pass-through of ram_q_b)
- acc_rd_pending  out  1  at least one accepted read not yet returned
- ccd_req  in  1  CCD write request, held until granted
- ccd_addr  in  ADDR_W  write address
- ccd_wdata  in  DATA_W  write data
- ccd_gnt  out  1  write accepted this cycle (combinational)
- ram_addr_b  out  ADDR_W  port-B address (registered)
- ram_data_b  out  DATA_W  port-B write data (registered)
- ram_rden_b  out  1  port-B read enable (registered)
- ram_wren_b  out  1  port-B write enable (registered)
- ram_q_b  in  DATA_W  port-B read data

## Operation
- Handshake: valid/ready. A transfer occurs in the cycle where `req && gnt`. `acc_gnt` and `ccd_gnt` are never high together. The grants depend only on current requests and registered arbiter state.
- Default priority is accelerator.
- `starve_cnt` (4-bit) increments each cycle when `ccd_req` is high and `acc_gnt` is high. It clears when `ccd_gnt` is high or `ccd_req` is low.
- When `starve_cnt == STARVE_MAX` and `ccd_req` is high, CCD wins that cycle regardless of `acc_req`.
- A lone requester is always granted the same cycle.
- Accepted read: at the next edge, register `ram_addr_b <= acc_addr`, `ram_rden_b <= 1`, `ram_wren_b <= 0`.
- Accepted write: at the next edge, register `ram_addr_b <= ccd_addr`, `ram_data_b <= ccd_wdata`, `ram_wren_b <= 1`, `ram_rden_b <= 0`.
- No transfer: `rden`/`wren` go to 0, while `ram_addr_b` and `ram_data_b` hold their last value.
- Read-return pipeline: a 1-bit shift register of depth RD_LAT is fed by `ram_rden_b`. Its output is `acc_rvalid`, and `acc_rdata = ram_q_b` unconditionally.
- Reads return in issue order. Back-to-back reads are fully pipelined, one per cycle.
- `acc_rd_pending` = `ram_rden_b` OR any stage of the pipeline.
- Port B performs at most one operation per cycle. Ordering at the RAM equals grant order; no reordering, no forwarding.

## Timing
- Reset (rst high at an edge): all registered outputs are 0 at the following cycle: `ram_addr_b`, `ram_data_b`, `ram_rden_b`, `ram_wren_b`. The pipeline and `starve_cnt` are also cleared.
- After reset, `acc_rvalid = 0` and `acc_rd_pending = 0`.
- While `rst` is high, `acc_gnt = ccd_gnt = 0`.
- Latency for a grant in cycle t:
  - RAM strobe in cycle t+1, high for exactly one cycle per grant.
  - `acc_rvalid` in cycle t+1+RD_LAT.
- Throughput: one grant per cycle total. Under continuous contention the pattern is STARVE_MAX accelerator grants then one CCD grant, repeating.
- Simultaneous request rise with `starve_cnt = 0`: accelerator wins; `starve_cnt` becomes 1.
- `ccd_req` dropping before grant is a protocol violation. The arbiter still clears `starve_cnt`; no write is issued.
- Reset mid-operation: all in-flight reads are discarded, and `acc_rvalid` is never asserted for them. A registered strobe present at the reset edge is cleared the next cycle. Requesters re-present after reset.
- `starve_cnt` saturates at STARVE_MAX; it never wraps.

## Test plan
- Reset with `acc_req = ccd_req = 1` → both grants 0 while rst high. Every registered output and `acc_rvalid` is 0 on the first cycle after release.
- Single read at addr 0x05, RD_LAT=2, grant in cycle t:
  - `acc_gnt` high in t.
  - `ram_rden_b = 1`, `ram_addr_b = 0x05` in t+1.
  - `acc_rvalid = 1` in t+3 with `acc_rdata` equal to the RAM model's word 0x05.
  - `acc_rd_pending` high t+1..t+2.
- Single write at addr 0x7F, data {16{16'hA5A5}}:
  - `ccd_gnt` in t.
  - `ram_wren_b = 1` with that address/data in t+1 only.
  - A later read of 0x7F returns the pattern.
- Both requesters held high 12 cycles, STARVE_MAX=4 → grant sequence A,A,A,A,C,A,A,A,A,C,A,A. Never both granted, never a cycle without a grant.
- Reads of 0x01, 0x02, 0x03 on consecutive cycles → `ram_rden_b` high three consecutive cycles. `acc_rvalid` high three consecutive cycles in order 0x01, 0x02, 0x03.
- Read granted in t, rst asserted in t+1 for one cycle → `ram_rden_b = 0` in t+2, `acc_rvalid` never asserted for that read, `acc_rd_pending = 0` from t+2.
